// File: rtl/proc_seq_pkg.sv
// Shared types and constants for the proc fetch/decode/execute sequencer.
// Instruction layout: {op[7:6], rd[5:4], rs1[3:2], rs2[1:0]}.
package proc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;

endpackage

// File: rtl/proc_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module proc_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [7:0] r3
);

  logic [3:0][7:0] regs;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      logic [7:0] q_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_reg <= '0;
        end else if (we && (waddr == 2'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];

endmodule

// File: rtl/proc_seq_ctrl.sv
// Fetch/decode/execute sequencer: imem fetch, register-file execute, pc and
// saturating retire counter. PROC_SEQ_TRACE_EN adds a registered retire trace port.
module proc_seq_ctrl
  import proc_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       start_pc,
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  input  logic             imem_rvalid,
  input  logic [7:0]       imem_rdata,
  output logic             busy,
  output logic             halted,
  output logic [7:0]       pc,
  output logic [7:0]       r0,
  output logic [7:0]       r1,
  output logic [7:0]       r2,
  output logic [7:0]       r3,
`ifdef PROC_SEQ_TRACE_EN
  output logic             retire_vld,
  output logic [7:0]       retire_pc,
  output logic [7:0]       retire_ir,
`endif
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [7:0]       pc_reg, pc_next;
  logic [7:0]       ir_reg, ir_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             halted_reg, halted_next;
  logic             req_reg, req_next;

  logic [1:0] op;
  logic [7:0] rs1_val, rs2_val;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;

  assign op = ir_reg[OP_MSB:OP_LSB];

  // Both operands are read combinationally before the write edge, so rd may alias rs1/rs2.
  assign rf_we    = (state_reg == EXEC) && ((op == OP_ADD) || (op == OP_SUB));
  assign rf_waddr = ir_reg[RD_MSB:RD_LSB];
  assign rf_wdata = (op == OP_SUB) ? (rs1_val - rs2_val) : (rs1_val + rs2_val);

  proc_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (ir_reg[RS1_MSB:RS1_LSB]),
    .rdata_a (rs1_val),
    .raddr_b (ir_reg[RS2_MSB:RS2_LSB]),
    .rdata_b (rs2_val),
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      pc_reg     <= '0;
      ir_reg     <= '0;
      cnt_reg    <= '0;
      halted_reg <= 1'b0;
      req_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      ir_reg     <= ir_next;
      cnt_reg    <= cnt_next;
      halted_reg <= halted_next;
      req_reg    <= req_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    cnt_next    = cnt_reg;
    halted_next = halted_reg;
    req_next    = req_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next     = start_pc;
          cnt_next    = '0;
          halted_next = 1'b0;
          req_next    = 1'b1;
          state_next  = FETCH;
        end
      end
      FETCH: begin
        if (imem_rvalid && req_reg) begin
          ir_next    = imem_rdata;
          req_next   = 1'b0;
          state_next = EXEC;
        end
      end
      EXEC: begin
        case (op)
          OP_NOP, OP_ADD, OP_SUB: begin
            pc_next = pc_reg + 8'd1;
            if (cnt_reg != CNT_MAX) begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
            req_next   = 1'b1;
            state_next = FETCH;
          end
          OP_HALT: begin
            halted_next = 1'b1;
            state_next  = IDLE;
          end
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_req   = req_reg;
  assign imem_addr  = pc_reg;
  assign busy       = (state_reg != IDLE);
  assign halted     = halted_reg;
  assign pc         = pc_reg;
  assign retire_cnt = cnt_reg;

`ifdef PROC_SEQ_TRACE_EN
  logic       retire_vld_reg;
  logic [7:0] retire_pc_reg, retire_ir_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_vld_reg <= 1'b0;
      retire_pc_reg  <= '0;
      retire_ir_reg  <= '0;
    end else begin
      retire_vld_reg <= (state_reg == EXEC);
      if (state_reg == EXEC) begin
        retire_pc_reg <= pc_reg;
        retire_ir_reg <= ir_reg;
      end
    end
  end

  assign retire_vld = retire_vld_reg;
  assign retire_pc  = retire_pc_reg;
  assign retire_ir  = retire_ir_reg;
`endif

endmodule
